// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem request, single output slot, redirect flush.
// Optional watchdog on memory acknowledge enabled by defining FETCH_TIMEOUT_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemAck,
  input  logic [31:0] imemRdata,
  input  logic        redirect,
  input  logic [31:0] redirectPc,
  input  logic        idStall,
  output logic        ifValid,
  output logic [31:0] instr,
  output logic [31:0] pcPlus4,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic        fetchFault
);

  typedef enum logic [2:0] {IDLE, REQ, FULL, DRAIN, HALT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic        valid_q, valid_d;
  logic [31:0] redir_pc;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("fetch_stage: TIMEOUT must be at least 1");
  end

  assign redir_pc = {redirectPc[31:2], 2'b00};

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (redirect) pc_d = redir_pc;
      end
      REQ: begin
        if (redirect) begin
          // A redirect always wins over a coincident ack; the word is dropped.
          pc_d    = redir_pc;
          valid_d = 1'b0;
          state_d = imemAck ? REQ : DRAIN;
        end else if (imemAck) begin
          instr_d = imemRdata;
          pcp4_d  = pc_q + 32'd4;
          pc_d    = pc_q + 32'd4;
          valid_d = 1'b1;
          state_d = FULL;
        end
      end
      FULL: begin
        if (redirect) begin
          pc_d    = redir_pc;
          valid_d = 1'b0;
          state_d = REQ;
        end else if (!idStall) begin
          valid_d = 1'b0;
          state_d = REQ;
        end
      end
      DRAIN: begin
        if (redirect) pc_d = redir_pc;
        valid_d = 1'b0;
        if (imemAck) state_d = REQ;
      end
      default: ;
    endcase

`ifdef FETCH_TIMEOUT_EN
    cnt_d   = '0;
    fault_d = fault_q;
    if ((state_q == REQ || state_q == DRAIN) && !imemAck) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_d == CNT_W'(TIMEOUT)) begin
        state_d = HALT;
        fault_d = 1'b1;
        valid_d = 1'b0;
      end
    end
`endif

    // The request address only moves when a fresh request is about to be issued.
    addr_d = (state_d == REQ) ? pc_d : addr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      instr_q <= '0;
      pcp4_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  assign fetchFault = fault_q;
`else
  assign fetchFault = 1'b0;
`endif

  assign imemReq  = (state_q == REQ) || (state_q == DRAIN);
  assign imemAddr = addr_q;
  assign ifValid  = valid_q;
  assign instr    = instr_q;
  assign pcPlus4  = pcp4_q;
  assign opcode   = instr_q[31:26];
  assign funct    = instr_q[5:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: per-cycle vector table plus reset and timeout sequences.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemRdata;
  logic        redirect;
  logic [31:0] redirectPc;
  logic        idStall;
  logic        ifValid;
  logic [31:0] instr;
  logic [31:0] pcPlus4;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        fetchFault;

  int n_vec = 0;
  int n_err = 0;

  fetch_stage #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemAck(imemAck), .imemRdata(imemRdata),
    .redirect(redirect), .redirectPc(redirectPc), .idStall(idStall),
    .ifValid(ifValid), .instr(instr), .pcPlus4(pcPlus4),
    .opcode(opcode), .funct(funct), .fetchFault(fetchFault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ack;
    logic [31:0] rdata;
    logic        redir;
    logic [31:0] rpc;
    logic        stall;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pcp4;
  } vec_t;

  localparam int NV = 24;
  vec_t tbl [NV];

  localparam logic [31:0] A0  = 32'h8C01_0004;
  localparam logic [31:0] A1  = 32'h0000_2020;
  localparam logic [31:0] A2  = 32'hAC22_0008;
  localparam logic [31:0] A3  = 32'h1000_FFFF;
  localparam logic [31:0] A4  = 32'h2408_0001;
  localparam logic [31:0] A5  = 32'hFC00_003F;
  localparam logic [31:0] BAD = 32'hDEAD_BEEF;

  function automatic vec_t mk(logic ack, logic [31:0] rdata, logic redir, logic [31:0] rpc,
                              logic stall, logic e_req, logic [31:0] e_addr, logic e_valid,
                              logic [31:0] e_instr, logic [31:0] e_pcp4);
    vec_t v;
    v = {ack, rdata, redir, rpc, stall, e_req, e_addr, e_valid, e_instr, e_pcp4};
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ack, input logic [31:0] rdata, input logic redir,
                       input logic [31:0] rpc, input logic stall);
    imemAck    = ack;
    imemRdata  = rdata;
    redirect   = redir;
    redirectPc = rpc;
    idStall    = stall;
  endtask

  initial begin
    //              ack rdata redir rpc            stall | req addr          valid instr pcp4
    tbl[0]  = mk(0, 0,   0, 0,             0,  0, 32'h0,         0, 32'h0, 32'h0);
    tbl[1]  = mk(1, A0,  0, 0,             0,  1, 32'h0,         0, 32'h0, 32'h0);
    tbl[2]  = mk(0, 0,   0, 0,             0,  0, 32'h0,         1, A0,    32'h4);
    tbl[3]  = mk(1, A1,  0, 0,             0,  1, 32'h4,         0, A0,    32'h4);
    tbl[4]  = mk(0, 0,   0, 0,             0,  0, 32'h0,         1, A1,    32'h8);
    tbl[5]  = mk(1, A2,  0, 0,             0,  1, 32'h8,         0, A1,    32'h8);
    tbl[6]  = mk(0, 0,   0, 0,             1,  0, 32'h0,         1, A2,    32'hC);
    tbl[7]  = mk(0, 0,   0, 0,             1,  0, 32'h0,         1, A2,    32'hC);
    tbl[8]  = mk(0, 0,   0, 0,             1,  0, 32'h0,         1, A2,    32'hC);
    tbl[9]  = mk(0, 0,   0, 0,             1,  0, 32'h0,         1, A2,    32'hC);
    tbl[10] = mk(0, 0,   0, 0,             1,  0, 32'h0,         1, A2,    32'hC);
    tbl[11] = mk(0, 0,   0, 0,             0,  0, 32'h0,         1, A2,    32'hC);
    tbl[12] = mk(0, 0,   1, 32'h0000_0203, 0,  1, 32'hC,         0, A2,    32'hC);
    tbl[13] = mk(0, 0,   1, 32'h0000_0103, 0,  1, 32'hC,         0, A2,    32'hC);
    tbl[14] = mk(1, BAD, 0, 0,             0,  1, 32'hC,         0, A2,    32'hC);
    tbl[15] = mk(1, A3,  0, 0,             0,  1, 32'h0000_0100, 0, A2,    32'hC);
    tbl[16] = mk(0, 0,   1, 32'hFFFF_FFFF, 1,  0, 32'h0,         1, A3,    32'h0000_0104);
    tbl[17] = mk(1, A4,  0, 0,             0,  1, 32'hFFFF_FFFC, 0, A3,    32'h0000_0104);
    tbl[18] = mk(0, 0,   0, 0,             0,  0, 32'h0,         1, A4,    32'h0);
    tbl[19] = mk(1, BAD, 1, 32'h0000_0040, 0,  1, 32'h0,         0, A4,    32'h0);
    tbl[20] = mk(0, 0,   0, 0,             0,  1, 32'h0000_0040, 0, A4,    32'h0);
    tbl[21] = mk(1, A5,  0, 0,             0,  1, 32'h0000_0040, 0, A4,    32'h0);
    tbl[22] = mk(0, 0,   0, 0,             1,  0, 32'h0,         1, A5,    32'h0000_0044);
    tbl[23] = mk(0, 0,   0, 0,             0,  0, 32'h0,         1, A5,    32'h0000_0044);

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].ack, tbl[i].rdata, tbl[i].redir, tbl[i].rpc, tbl[i].stall);
      #1;
      chk($sformatf("row%0d imemReq", i), 32'(imemReq), 32'(tbl[i].e_req));
      if (tbl[i].e_req) chk($sformatf("row%0d imemAddr", i), imemAddr, tbl[i].e_addr);
      chk($sformatf("row%0d ifValid", i), 32'(ifValid), 32'(tbl[i].e_valid));
      chk($sformatf("row%0d instr", i), instr, tbl[i].e_instr);
      chk($sformatf("row%0d pcPlus4", i), pcPlus4, tbl[i].e_pcp4);
      chk($sformatf("row%0d opcode", i), 32'(opcode), 32'(tbl[i].e_instr[31:26]));
      chk($sformatf("row%0d funct", i), 32'(funct), 32'(tbl[i].e_instr[5:0]));
      chk($sformatf("row%0d fetchFault", i), 32'(fetchFault), 32'h0);
      @(negedge clk);
    end

    // Reset asserted in the middle of a request to 0x44
    drive(0, 0, 0, 0, 0);
    #1;
    chk("pre-reset imemReq", 32'(imemReq), 32'h1);
    chk("pre-reset imemAddr", imemAddr, 32'h0000_0044);
    #1 rst_n = 1'b0;
    #1;
    chk("async reset imemReq", 32'(imemReq), 32'h0);
    chk("async reset imemAddr", imemAddr, 32'h0);
    chk("async reset ifValid", 32'(ifValid), 32'h0);
    chk("async reset instr", instr, 32'h0);
    chk("async reset pcPlus4", pcPlus4, 32'h0);
    chk("async reset fetchFault", 32'(fetchFault), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, BAD, 0, 0, 0);
    #1;
    chk("idle imemReq", 32'(imemReq), 32'h0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    #1;
    chk("stray ack ifValid", 32'(ifValid), 32'h0);
    chk("first req imemReq", 32'(imemReq), 32'h1);
    chk("first req imemAddr", imemAddr, 32'h0);

    // Memory never acknowledges
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      #1;
`ifdef FETCH_TIMEOUT_EN
      chk($sformatf("wait%0d fetchFault", i), 32'(fetchFault), (i >= 16) ? 32'h1 : 32'h0);
      chk($sformatf("wait%0d imemReq", i), 32'(imemReq), (i >= 16) ? 32'h0 : 32'h1);
`else
      chk($sformatf("wait%0d fetchFault", i), 32'(fetchFault), 32'h0);
      chk($sformatf("wait%0d imemReq", i), 32'(imemReq), 32'h1);
      chk($sformatf("wait%0d imemAddr", i), imemAddr, 32'h0);
`endif
      chk($sformatf("wait%0d ifValid", i), 32'(ifValid), 32'h0);
    end

`ifdef FETCH_TIMEOUT_EN
    drive(1, A0, 1, 32'h0000_0200, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("halt redirect fetchFault", 32'(fetchFault), 32'h1);
    chk("halt redirect imemReq", 32'(imemReq), 32'h0);
    chk("halt redirect ifValid", 32'(ifValid), 32'h0);
    drive(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("fault cleared by reset", 32'(fetchFault), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
